// File: rtl/mem_arbiter.sv
// Shared main-memory sequencer: arbitrates I-miss fills, D-miss fills and
// write-through stores, generates fill bursts and steers returned words.
module mem_arbiter #(
    parameter int unsigned WORDS  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [15:0]       d_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic              fill_we,
    output logic              fill_sel_d,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [15:0]       fill_data,
    output logic              i_done,
    output logic              d_done,
    output logic              wr_done,
    output logic              busy
);

    localparam int unsigned LOG_W = $clog2(WORDS);
    localparam int unsigned CNT_W = LOG_W + 1;
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << (LOG_W + 1)) - 1);
    localparam logic [CNT_W-1:0]  CNT_WORDS = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic              r_sel;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic [CNT_W-1:0]  r_ret_cnt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [15:0]       r_wr_data;
    logic              r_i_done;
    logic              r_d_done;

    logic              w_grant_wr;
    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_issue;
    logic              w_ret;
    logic              w_ret_last;
    logic [ADDR_W-1:0] w_issue_off;
    logic [ADDR_W-1:0] w_ret_off;

    assign w_issue_off = ADDR_W'(r_issue_cnt) << 1;
    assign w_ret_off   = ADDR_W'(r_ret_cnt) << 1;
    assign w_ret_last  = (r_ret_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration, next state and memory/fill outputs
    always_comb begin
        w_state_nxt = r_state;
        w_grant_wr  = 1'b0;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        w_issue     = 1'b0;
        w_ret       = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_we     = 1'b0;
        fill_sel_d  = 1'b0;
        fill_addr   = '0;
        fill_data   = '0;
        wr_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Data side is older in the pipeline, so it always wins
                if (d_wr) begin
                    w_grant_wr  = 1'b1;
                    w_state_nxt = ST_WRITE;
                end else if (d_miss) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = ST_FILL;
                end else if (i_miss) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_WRITE: begin
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = r_wr_addr;
                mem_wdata   = r_wr_data;
                wr_done     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_FILL: begin
                if (r_issue_cnt < CNT_WORDS) begin
                    w_issue  = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = r_base + w_issue_off;
                end
                // Returns overlap issue; words are matched purely by arrival order
                if (mem_valid) begin
                    w_ret      = 1'b1;
                    fill_we    = 1'b1;
                    fill_sel_d = r_sel;
                    fill_addr  = r_base + w_ret_off;
                    fill_data  = mem_rdata;
                    if (w_ret_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, burst counters and registered done pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base      <= '0;
            r_sel       <= 1'b0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            if (w_grant_wr) begin
                r_wr_addr <= d_wr_addr;
                r_wr_data <= d_wr_data;
            end
            if (w_grant_d || w_grant_i) begin
                r_base      <= (w_grant_d ? d_miss_addr : i_miss_addr) & BASE_MASK;
                r_sel       <= w_grant_d;
                r_issue_cnt <= '0;
                r_ret_cnt   <= '0;
            end else begin
                if (w_issue) begin
                    r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                end
                if (w_ret) begin
                    r_ret_cnt <= r_ret_cnt + CNT_W'(1);
                    if (w_ret_last) begin
                        r_d_done <= r_sel;
                        r_i_done <= ~r_sel;
                    end
                end
            end
        end
    end

    assign i_done = r_i_done;
    assign d_done = r_d_done;
    assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fixed-latency memory model answers reads,
// a negedge monitor logs issues/fills/dones, and each scenario checks the logs.
module tb_mem_arbiter;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
        logic        f;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_miss = 1'b0;
    logic [15:0] i_miss_addr = '0;
    logic        d_miss = 1'b0;
    logic [15:0] d_miss_addr = '0;
    logic        d_wr = 1'b0;
    logic [15:0] d_wr_addr = '0;
    logic [15:0] d_wr_data = '0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_valid;
    logic        fill_we, fill_sel_d;
    logic [15:0] fill_addr, fill_data;
    logic        i_done, d_done, wr_done, busy;

    logic        spur_valid = 1'b0;
    logic [4:0]  r_vpipe = '0;
    logic [15:0] r_apipe [5];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   idle_vld = 0;
    ev_t  iss_q[$];
    ev_t  fill_q[$];
    ev_t  done_q[$];

    mem_arbiter #(.WORDS(8), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_we(fill_we), .fill_sel_d(fill_sel_d), .fill_addr(fill_addr), .fill_data(fill_data),
        .i_done(i_done), .d_done(d_done), .wr_done(wr_done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: read issued in cycle c returns in cycle c+5, data = addr ^ 5A5A
    always @(posedge clk) begin
        r_vpipe    <= {r_vpipe[3:0], mem_en & ~mem_wr};
        r_apipe[0] <= mem_addr;
        for (int i = 1; i < 5; i++) r_apipe[i] <= r_apipe[i-1];
    end
    assign mem_valid = r_vpipe[4] | spur_valid;
    assign mem_rdata = r_vpipe[4] ? (r_apipe[4] ^ 16'h5A5A) : 16'hDEAD;

    function automatic ev_t mk(int c, logic [15:0] a, logic [15:0] d, logic f);
        ev_t e;
        e.cyc = c; e.addr = a; e.data = d; e.f = f;
        return e;
    endfunction

    // Monitor and well-behaved requesters that drop on their done pulse
    always @(negedge clk) begin
        if (mem_en)  iss_q.push_back(mk(cyc, mem_addr, mem_wdata, mem_wr));
        if (fill_we) fill_q.push_back(mk(cyc, fill_addr, fill_data, fill_sel_d));
        if (i_done)  done_q.push_back(mk(cyc, 16'd0, 16'd0, 1'b0));
        if (d_done)  done_q.push_back(mk(cyc, 16'd1, 16'd0, 1'b0));
        if (wr_done) done_q.push_back(mk(cyc, 16'd2, 16'd0, 1'b0));
        if (mem_valid && !busy) idle_vld++;
        if (i_done)  i_miss = 1'b0;
        if (d_done)  d_miss = 1'b0;
        if (wr_done) d_wr   = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        iss_q.delete();
        fill_q.delete();
        done_q.delete();
    endtask

    task automatic test_reset();
        logic [83:0] outs;
        rst = 1'b1;
        tick();
        tick();
        outs = {mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_sel_d,
                fill_addr, fill_data, i_done, d_done, wr_done, busy};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b mem_en=%b exp 0/0", busy, mem_en);
        end
    endtask

    task automatic test_i_fill();
        int c0;
        logic [15:0] ea;
        clear_logs();
        c0 = cyc;
        i_miss_addr = 16'h1234;
        i_miss = 1'b1;
        repeat (30) tick();
        checks++;
        if (iss_q.size() != 8) begin
            failures++;
            $display("FAIL ifill_issue_count got=%0d exp=8", iss_q.size());
        end
        for (int k = 0; k < 8; k++) begin
            ea = 16'h1230 + 16'(2 * k);
            checks++;
            if (k >= iss_q.size() || iss_q[k].addr !== ea || iss_q[k].cyc != c0 + 1 + k || iss_q[k].f !== 1'b0) begin
                failures++;
                $display("FAIL ifill_issue[%0d] got addr=%h cyc=%0d exp addr=%h cyc=%0d", k,
                         iss_q[k].addr, iss_q[k].cyc, ea, c0 + 1 + k);
            end
            checks++;
            if (k >= fill_q.size() || fill_q[k].addr !== ea || fill_q[k].data !== (ea ^ 16'h5A5A) || fill_q[k].f !== 1'b0) begin
                failures++;
                $display("FAIL ifill_fill[%0d] got addr=%h data=%h sel=%b exp addr=%h data=%h sel=0", k,
                         fill_q[k].addr, fill_q[k].data, fill_q[k].f, ea, ea ^ 16'h5A5A);
            end
        end
        checks++;
        if (fill_q.size() != 8 || done_q.size() != 1 || done_q[0].addr !== 16'd0 || done_q[0].cyc != c0 + 14) begin
            failures++;
            $display("FAIL ifill_done got fills=%0d dones=%0d kind=%0d cyc=%0d exp 8/1/0/%0d",
                     fill_q.size(), done_q.size(), done_q[0].addr, done_q[0].cyc, c0 + 14);
        end
    endtask

    task automatic test_d_priority();
        int c0;
        logic [15:0] ea;
        logic        es;
        clear_logs();
        c0 = cyc;
        i_miss_addr = 16'h2000;
        d_miss_addr = 16'h3456;
        i_miss = 1'b1;
        d_miss = 1'b1;
        repeat (50) tick();
        checks++;
        if (iss_q.size() != 16 || fill_q.size() != 16) begin
            failures++;
            $display("FAIL prio_counts got issues=%0d fills=%0d exp 16/16", iss_q.size(), fill_q.size());
        end
        for (int k = 0; k < 16; k++) begin
            ea = (k < 8) ? 16'h3450 + 16'(2 * k) : 16'h2000 + 16'(2 * (k - 8));
            es = (k < 8);
            checks++;
            if (k >= fill_q.size() || fill_q[k].addr !== ea || fill_q[k].f !== es || fill_q[k].data !== (ea ^ 16'h5A5A)) begin
                failures++;
                $display("FAIL prio_fill[%0d] got addr=%h sel=%b exp addr=%h sel=%b", k,
                         fill_q[k].addr, fill_q[k].f, ea, es);
            end
        end
        checks++;
        if (done_q.size() != 2 || done_q[0].addr !== 16'd1 || done_q[0].cyc != c0 + 14
            || done_q[1].addr !== 16'd0 || done_q[1].cyc != c0 + 28) begin
            failures++;
            $display("FAIL prio_done got n=%0d first=%0d@%0d second=%0d@%0d exp 2 1@%0d 0@%0d",
                     done_q.size(), done_q[0].addr, done_q[0].cyc, done_q[1].addr, done_q[1].cyc,
                     c0 + 14, c0 + 28);
        end
        checks++;
        if (iss_q.size() < 9 || iss_q[8].cyc != c0 + 15 || iss_q[8].addr !== 16'h2000) begin
            failures++;
            $display("FAIL prio_i_start got cyc=%0d addr=%h exp cyc=%0d addr=2000",
                     iss_q[8].cyc, iss_q[8].addr, c0 + 15);
        end
    endtask

    task automatic test_wr_first();
        int c0;
        logic [15:0] ea;
        clear_logs();
        c0 = cyc;
        d_wr_addr = 16'h0042;
        d_wr_data = 16'hBEEF;
        d_miss_addr = 16'h0100;
        d_wr = 1'b1;
        d_miss = 1'b1;
        repeat (30) tick();
        checks++;
        if (iss_q.size() != 9 || iss_q[0].f !== 1'b1 || iss_q[0].addr !== 16'h0042
            || iss_q[0].data !== 16'hBEEF || iss_q[0].cyc != c0 + 1) begin
            failures++;
            $display("FAIL wr_cycle got n=%0d wr=%b addr=%h data=%h cyc=%0d exp 9 1 0042 BEEF %0d",
                     iss_q.size(), iss_q[0].f, iss_q[0].addr, iss_q[0].data, iss_q[0].cyc, c0 + 1);
        end
        for (int k = 1; k < 9; k++) begin
            ea = 16'h0100 + 16'(2 * (k - 1));
            checks++;
            if (k >= iss_q.size() || iss_q[k].f !== 1'b0 || iss_q[k].addr !== ea || iss_q[k].cyc != c0 + 2 + k) begin
                failures++;
                $display("FAIL wr_then_fill[%0d] got addr=%h wr=%b cyc=%0d exp addr=%h wr=0 cyc=%0d", k,
                         iss_q[k].addr, iss_q[k].f, iss_q[k].cyc, ea, c0 + 2 + k);
            end
        end
        checks++;
        if (done_q.size() != 2 || done_q[0].addr !== 16'd2 || done_q[0].cyc != c0 + 1
            || done_q[1].addr !== 16'd1 || done_q[1].cyc != c0 + 16) begin
            failures++;
            $display("FAIL wr_done_order got n=%0d %0d@%0d %0d@%0d exp 2@%0d 1@%0d",
                     done_q.size(), done_q[0].addr, done_q[0].cyc, done_q[1].addr, done_q[1].cyc,
                     c0 + 1, c0 + 16);
        end
        checks++;
        if (fill_q.size() != 8 || fill_q[0].f !== 1'b1 || fill_q[7].addr !== 16'h010E) begin
            failures++;
            $display("FAIL wr_dfill got n=%0d sel=%b last=%h exp 8 1 010E",
                     fill_q.size(), fill_q[0].f, fill_q[7].addr);
        end
    endtask

    task automatic test_spurious();
        int c0;
        logic [15:0] ea;
        clear_logs();
        spur_valid = 1'b1;
        repeat (3) tick();
        d_wr_addr = 16'h0010;
        d_wr_data = 16'h1111;
        d_wr = 1'b1;
        repeat (2) tick();
        spur_valid = 1'b0;
        tick();
        checks++;
        if (fill_q.size() != 0 || done_q.size() != 1 || done_q[0].addr !== 16'd2) begin
            failures++;
            $display("FAIL spur_ignored got fills=%0d dones=%0d kind=%0d exp 0/1/2",
                     fill_q.size(), done_q.size(), done_q[0].addr);
        end
        clear_logs();
        c0 = cyc;
        i_miss_addr = 16'h0046;
        i_miss = 1'b1;
        repeat (30) tick();
        for (int k = 0; k < 8; k++) begin
            ea = 16'h0040 + 16'(2 * k);
            checks++;
            if (k >= fill_q.size() || fill_q[k].addr !== ea || fill_q[k].cyc != c0 + 6 + k) begin
                failures++;
                $display("FAIL spur_after_fill[%0d] got addr=%h cyc=%0d exp addr=%h cyc=%0d", k,
                         fill_q[k].addr, fill_q[k].cyc, ea, c0 + 6 + k);
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0].addr !== 16'd0 || done_q[0].cyc != c0 + 14) begin
            failures++;
            $display("FAIL spur_after_done got n=%0d kind=%0d cyc=%0d exp 1/0/%0d",
                     done_q.size(), done_q[0].addr, done_q[0].cyc, c0 + 14);
        end
    endtask

    task automatic test_reset_mid();
        int          n_iss;
        int          t;
        logic [83:0] outs;
        clear_logs();
        i_miss_addr = 16'h0800;
        i_miss = 1'b1;
        t = 0;
        while (fill_q.size() < 3 && t < 40) begin
            tick();
            t++;
        end
        checks++;
        if (fill_q.size() < 3) begin
            failures++;
            $display("FAIL rstmid_timeout got fills=%0d exp 3", fill_q.size());
        end
        rst = 1'b1;
        i_miss = 1'b0;
        #1;
        outs = {mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_sel_d,
                fill_addr, fill_data, i_done, d_done, wr_done, busy};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%h exp=0", outs);
        end
        n_iss = iss_q.size();
        tick();
        rst = 1'b0;
        idle_vld = 0;
        repeat (15) tick();
        checks++;
        if (fill_q.size() != 3 || done_q.size() != 0 || iss_q.size() != n_iss) begin
            failures++;
            $display("FAIL rstmid_abort got fills=%0d dones=%0d issues=%0d exp 3/0/%0d",
                     fill_q.size(), done_q.size(), iss_q.size(), n_iss);
        end
        checks++;
        if (idle_vld == 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_late_valid got idle_valids=%0d busy=%b exp >0/0", idle_vld, busy);
        end
    endtask

    task automatic test_wrap();
        int c0;
        logic [15:0] ea;
        clear_logs();
        c0 = cyc;
        d_miss_addr = 16'hFFF7;
        d_miss = 1'b1;
        repeat (30) tick();
        for (int k = 0; k < 8; k++) begin
            ea = 16'hFFF0 + 16'(2 * k);
            checks++;
            if (k >= iss_q.size() || iss_q[k].addr !== ea || k >= fill_q.size() || fill_q[k].addr !== ea
                || fill_q[k].f !== 1'b1) begin
                failures++;
                $display("FAIL wrap_addr[%0d] got issue=%h fill=%h sel=%b exp %h sel=1", k,
                         iss_q[k].addr, fill_q[k].addr, fill_q[k].f, ea);
            end
        end
        checks++;
        if (fill_q.size() != 8 || fill_q[7].addr !== 16'hFFFE || done_q.size() != 1
            || done_q[0].addr !== 16'd1 || done_q[0].cyc != c0 + 14) begin
            failures++;
            $display("FAIL wrap_end got fills=%0d last=%h dones=%0d kind=%0d cyc=%0d exp 8 FFFE 1 1 %0d",
                     fill_q.size(), fill_q[7].addr, done_q.size(), done_q[0].addr, done_q[0].cyc, c0 + 14);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_i_fill();
        test_d_priority();
        test_wr_first();
        test_spurious();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
